rr_mux_reg: RTL and testbench
=============================

// Module: rr_mux_reg
// PURPOSE
//  Parametrised N-channel, W-bit registered multiplexer with valid/ready handshake.
//  Successor to the 4:1 single-bit mux used in the lab datapath.
//  Selects one input channel per transfer, either round-robin or forced by a select
//  code, and holds the result in a one-entry output register.
//  Sits between the per-channel producers and a single downstream consumer.
// PARAMETERS
//  N_CH   4  number of input channels (>=2)
//  WIDTH  8  data width per channel, bits
//  SEL_W  $clog2(N_CH)  select/index width (derived, do not override)
// PORTS
//  clk        in   1           rising-edge clock
//  rst_n      in   1           asynchronous reset, active-low
//  mode       in   1           0 = round-robin arbitration, 1 = forced select
//  sel        in   SEL_W       channel index used when mode=1
//  in_valid   in   N_CH        per-channel data valid
//  in_data    in   N_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
//  in_ready   out  N_CH        per-channel accept strobe (one-hot or zero)
//  out_valid  out  1           output register holds data
//  out_data   out  WIDTH       registered selected data
//  out_ch     out  SEL_W       index of the channel that supplied out_data
//  out_ready  in   1           consumer accepts out_data this cycle
// BEHAVIOUR
//  Reset (rst_n=0, async): out_valid=0, out_data=0, out_ch=0, rr_ptr=0, state=EMPTY.
//    in_ready=0 while rst_n=0. A transfer in flight at reset is dropped.
//  FSM: EMPTY (out_valid=0), FULL (out_valid=1).
//  load = (state==EMPTY) | out_ready. A pass-through refill is allowed when FULL
//    and out_ready=1.
//  Grant, combinational, evaluated only when load=1:
//   - mode=0: first i with in_valid[i]=1, searching rr_ptr, rr_ptr+1, ... mod N_CH.
//   - mode=1: i=sel if in_valid[sel]=1, else no grant.
//   - sel >= N_CH (when N_CH is not a power of 2): no grant.
//  in_ready[i] = load & grant[i]. It is a one-hot, or all-zero when there is no
//    grant. It is never asserted for a channel with in_valid=0.
//  Transfer into channel i occurs when in_valid[i] & in_ready[i] at a clk edge. Next cycle:
//    out_data=in_data[i], out_ch=i, out_valid=1, state=FULL.
//  Latency: 1 cycle from the input handshake to out_valid.
//  rr_ptr <= (i+1) mod N_CH on every transfer, in both modes.
//    The pointer is unchanged when there is no transfer.
//  FULL & out_ready & no grant -> state EMPTY, out_valid=0.
//    out_data and out_ch hold their last values.
//  FULL & ~out_ready -> all registers hold and in_ready=0.
//    out_data is stable while out_valid=1 and out_ready=0.
//  mode or sel may change on any cycle. The change takes effect on the next
//    grant evaluation, with no pipeline flush.
//  Throughput: 1 transfer/cycle while out_ready=1 and any eligible channel is valid.
//  No combinational path from out_ready to out_valid or out_data.
//    The out_ready -> in_ready path is permitted.
// TESTING
//  1. Reset: rst_n=0 mid-transfer with in_valid=4'b1111 -> out_valid=0, out_data=0,
//     in_ready=0 immediately, without waiting for a clk edge.
//  2. RR fairness: N_CH=4, mode=0, all valid, out_ready=1 for 8 cycles ->
//     out_ch sequence 0,1,2,3,0,1,2,3; one transfer per cycle.
//  3. Sparse RR: in_valid=4'b1010, rr_ptr=0 -> grants ch1 then ch3 then ch1;
//     in_ready never set on ch0/ch2.
//  4. Forced: mode=1, sel=2, in_data[ch2]=8'hA5, in_valid=4'b1111 -> out_data=8'hA5,
//     out_ch=2 every transfer; sel=2 with in_valid[2]=0 -> in_ready=0, out_valid drops.
//  5. Backpressure: FULL with out_data=8'h3C, out_ready=0 for 5 cycles ->
//     out_data/out_ch stable, in_ready=0; out_ready=1 -> next channel loads same cycle.
//  6. Drain: single transfer then in_valid=0, out_ready=1 -> out_valid high 1 cycle, then 0.

Source files
------------

// File: rtl/rr_mux_reg.sv
// rtl/rr_mux_reg.sv - N-channel registered mux with round-robin or forced select
module rr_mux_reg #(
   parameter int N_CH  = 4,
   parameter int WIDTH = 8,
   parameter int SEL_W = $clog2(N_CH)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    mode,
   input  logic [SEL_W-1:0]        sel,
   input  logic [N_CH-1:0]         in_valid,
   input  logic [N_CH*WIDTH-1:0]   in_data,
   output logic [N_CH-1:0]         in_ready,
   output logic                    out_valid,
   output logic [WIDTH-1:0]        out_data,
   output logic [SEL_W-1:0]        out_ch,
   input  logic                    out_ready
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   localparam logic [SEL_W:0]   N_CH_X  = (SEL_W+1)'(N_CH);
   localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH-1);

   state_t           state;
   state_t           state_nxt;
   logic [SEL_W-1:0] rr_ptr;
   logic [SEL_W-1:0] grant_idx;
   logic [SEL_W-1:0] cand_idx;
   logic [SEL_W:0]   cand_sum;
   logic             grant_vld;
   logic             load;
   logic             xfer;
   logic             sel_ok;

   assign load   = (state == EMPTY) | out_ready;
   assign sel_ok = {1'b0, sel} < N_CH_X;
   assign xfer   = load & grant_vld;

   // Descending scan so the lowest rotated offset from rr_ptr wins.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      cand_sum  = '0;
      cand_idx  = '0;
      if (mode) begin
         if (sel_ok && in_valid[sel]) begin
            grant_vld = 1'b1;
            grant_idx = sel;
         end
      end else begin
         for (int k = N_CH - 1; k >= 0; k--) begin
            cand_sum = {1'b0, rr_ptr} + (SEL_W+1)'(k);
            if (cand_sum >= N_CH_X) begin
               cand_sum = cand_sum - N_CH_X;
            end
            cand_idx = cand_sum[SEL_W-1:0];
            if (in_valid[cand_idx]) begin
               grant_vld = 1'b1;
               grant_idx = cand_idx;
            end
         end
      end
   end

   always_comb begin
      in_ready = '0;
      for (int i = 0; i < N_CH; i++) begin
         in_ready[i] = rst_n & xfer & (grant_idx == SEL_W'(i));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (xfer) begin
         state_nxt = FULL;
      end else if (out_ready) begin
         state_nxt = EMPTY;
      end
   end

   always_comb begin
      out_valid = (state == FULL);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data <= '0;
         out_ch   <= '0;
         rr_ptr   <= '0;
      end else if (xfer) begin
         out_data <= in_data[grant_idx*WIDTH +: WIDTH];
         out_ch   <= grant_idx;
         rr_ptr   <= (grant_idx == LAST_CH) ? '0 : grant_idx + 1'b1;
      end
   end

endmodule

// File: tb/tb_rr_mux_reg.sv
// tb/tb_rr_mux_reg.sv - self-checking bench for rr_mux_reg
module tb_rr_mux_reg;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int SW = 2;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            mode = 1'b0;
   logic [SW-1:0]   sel = '0;
   logic [N-1:0]    in_valid = '0;
   logic [N*W-1:0]  in_data = '0;
   logic [N-1:0]    in_ready;
   logic            out_valid;
   logic [W-1:0]    out_data;
   logic [SW-1:0]   out_ch;
   logic            out_ready = 1'b0;

   int n_cmp = 0;
   int n_err = 0;

   int m_valid = 0;
   int m_data  = 0;
   int m_ch    = 0;
   int m_ptr   = 0;

   rr_mux_reg #(.N_CH(N), .WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mode      (mode),
      .sel       (sel),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ch    (out_ch),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: evaluated on the falling edge, between input updates and the next rising edge.
   always @(negedge clk) begin
      int g;
      int c;
      int exp_rdy;
      if (!rst_n) begin
         m_valid = 0;
         m_data  = 0;
         m_ch    = 0;
         m_ptr   = 0;
         check("rst_in_ready", int'(in_ready), 0);
         check("rst_out_valid", int'(out_valid), 0);
      end else begin
         g = -1;
         if (m_valid == 0 || out_ready) begin
            if (mode) begin
               if (int'(sel) < N && in_valid[sel]) g = int'(sel);
            end else begin
               for (int k = 0; k < N; k++) begin
                  c = (m_ptr + k) % N;
                  if (g < 0 && in_valid[c]) g = c;
               end
            end
         end
         exp_rdy = (g >= 0) ? (1 << g) : 0;
         check("model_in_ready", int'(in_ready), exp_rdy);
         check("model_out_valid", int'(out_valid), m_valid);
         check("model_out_data", int'(out_data), m_data);
         check("model_out_ch", int'(out_ch), m_ch);
         if (g >= 0) begin
            m_valid = 1;
            m_data  = int'(in_data[g*W +: W]);
            m_ch    = g;
            m_ptr   = (g + 1) % N;
         end else if (out_ready) begin
            m_valid = 0;
         end
      end
   end

   initial begin
      int exp3 [3];
      logic [W-1:0] ch2_byte;
      exp3 = '{1, 3, 1};

      repeat (2) tick();
      rst_n = 1'b1;

      // Asynchronous reset while transfers are streaming
      mode = 1'b0;
      in_valid = 4'b1111;
      in_data = 32'h44332211;
      out_ready = 1'b1;
      tick();
      tick();
      check("t1_pre_out_valid", int'(out_valid), 1);
      check("t1_pre_out_data", int'(out_data), 8'h22);
      #2;
      rst_n = 1'b0;
      #1;
      check("t1_out_valid", int'(out_valid), 0);
      check("t1_out_data", int'(out_data), 0);
      check("t1_in_ready", int'(in_ready), 0);
      tick();
      rst_n = 1'b1;

      // Round-robin over all-valid channels
      #1;
      check("t2_first_ready", int'(in_ready), 4'b0001);
      for (int k = 0; k < 8; k++) begin
         tick();
         check("t2_out_ch", int'(out_ch), k % 4);
         check("t2_out_valid", int'(out_valid), 1);
      end

      // Sparse round-robin from a fresh pointer
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      in_valid = 4'b1010;
      for (int k = 0; k < 3; k++) begin
         #1;
         check("t3_no_ready_even", int'(in_ready & 4'b0101), 0);
         tick();
         check("t3_out_ch", int'(out_ch), exp3[k]);
      end

      // Forced select
      mode = 1'b1;
      sel = 2'd2;
      in_data = 32'h44A52211;
      in_valid = 4'b1111;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("t4_out_data", int'(out_data), 8'hA5);
         check("t4_out_ch", int'(out_ch), 2);
      end
      in_valid = 4'b1011;
      #1;
      check("t4_in_ready_none", int'(in_ready), 0);
      tick();
      check("t4_out_valid_drop", int'(out_valid), 0);

      // Backpressure holds the register, release loads the next channel the same cycle
      sel = 2'd1;
      in_data = 32'h00003C00;
      in_valid = 4'b0010;
      tick();
      check("t5_load_data", int'(out_data), 8'h3C);
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         in_data = $urandom;
         in_valid = 4'($urandom);
         tick();
         check("t5_hold_data", int'(out_data), 8'h3C);
         check("t5_hold_ch", int'(out_ch), 1);
         check("t5_hold_valid", int'(out_valid), 1);
         check("t5_hold_ready", int'(in_ready), 0);
      end
      mode = 1'b0;
      in_valid = 4'b1111;
      ch2_byte = in_data[2*W +: W];
      out_ready = 1'b1;
      #1;
      check("t5_release_ready", int'(in_ready), 4'b0100);
      tick();
      check("t5_release_ch", int'(out_ch), 2);
      check("t5_release_data", int'(out_data), int'(ch2_byte));

      // Drain after a single transfer
      in_valid = 4'b0000;
      tick();
      check("t6_empty", int'(out_valid), 0);
      in_valid = 4'b0001;
      tick();
      check("t6_one_valid", int'(out_valid), 1);
      check("t6_one_ch", int'(out_ch), 0);
      in_valid = 4'b0000;
      tick();
      check("t6_drained", int'(out_valid), 0);

      // Randomized traffic, including one mid-run reset
      for (int k = 0; k < 3000; k++) begin
         mode = ($urandom % 4) == 0;
         sel = SW'($urandom);
         in_valid = N'($urandom);
         in_data = $urandom;
         out_ready = ($urandom % 4) != 0;
         if (k == 1500) begin
            rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
         end
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
